// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes,
// response record and load lane extraction.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              write;
    logic              error;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  localparam int unsigned RSP_W = $bits(rsp_t);

  // Select the addressed lane(s), right-justify and sign/zero extend.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [1:0]        lane,
                                                    input size_e             size,
                                                    input logic              uns);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = {{24{b[7] & ~uns}}, b};
      SIZE_HALF: r = {{16{h[15] & ~uns}}, h};
      SIZE_WORD: r = word;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the memory stage and the data-memory responder.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_write;
  logic              rsp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_error
  );

endinterface

// File: rtl/dmem_responder_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of 2 (>= 2).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte lanes, fixed-latency pipeline and a
// credit-limited in-order response FIFO.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned RSP_DEPTH   = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic              ready_en_q;
  logic              accept, err, pop, push;
  logic [31:0]       off, outstanding, inflight;
  logic [AW-1:0]     widx;
  size_e             size;
  logic [3:0]        be;
  logic [DATA_W-1:0] wd, rd_word;
  rsp_t              rsp_new, push_data, head;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_cnt;

  assign off    = bus.req_addr - BASE_ADDR;
  assign size   = size_e'(bus.req_size);
  assign widx   = off[AW+1:2];
  assign accept = bus.req_valid & bus.req_ready;

  always_comb begin
    err = (off[31:AW+2] != '0);
    case (size)
      SIZE_BYTE: err = err;
      SIZE_HALF: err = err | off[0];
      SIZE_WORD: err = err | (off[1:0] != 2'b00);
      default:   err = 1'b1;
    endcase
  end

  // Replicate store data across lanes so the enable alone picks the target bytes.
  always_comb begin
    be = '0;
    wd = bus.req_wdata;
    case (size)
      SIZE_BYTE: begin
        be = 4'b0001 << off[1:0];
        wd = {4{bus.req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        be = off[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.req_wdata[15:0]}};
      end
      SIZE_WORD: be = '1;
      default:   be = '0;
    endcase
    if (!(accept && bus.req_write && !err)) be = '0;
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
    end
  end

  assign rd_word       = mem[widx];
  assign rsp_new.write = bus.req_write;
  assign rsp_new.error = err;
  assign rsp_new.rdata = (bus.req_write || err) ? '0
                       : load_extend(rd_word, off[1:0], size, bus.req_unsigned);

  // The FIFO write is the last latency stage, so only LATENCY-1 registers precede it.
  if (LATENCY == 1) begin : g_lat1
    assign push      = accept;
    assign push_data = rsp_new;
    assign inflight  = '0;
  end else begin : g_pipe
    logic pv_q [LATENCY-1];
    rsp_t pd_q [LATENCY-1];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned i = 0; i < LATENCY - 1; i++) pv_q[i] <= 1'b0;
      end else begin
        pv_q[0] <= accept;
        for (int unsigned i = 1; i < LATENCY - 1; i++) pv_q[i] <= pv_q[i-1];
      end
    end

    always_ff @(posedge clock) begin
      pd_q[0] <= rsp_new;
      for (int unsigned i = 1; i < LATENCY - 1; i++) pd_q[i] <= pd_q[i-1];
    end

    always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < LATENCY - 1; i++) inflight = inflight + 32'(pv_q[i]);
    end

    assign push      = pv_q[LATENCY-2];
    assign push_data = pd_q[LATENCY-2];
  end

  sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ready_en_q <= 1'b0;
    else          ready_en_q <= 1'b1;
  end

  assign outstanding   = 32'(fifo_cnt) + inflight;
  assign bus.req_ready = ready_en_q & ~fifo_full & (outstanding < RSP_DEPTH);
  assign bus.rsp_valid = ~fifo_empty;
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign bus.rsp_rdata = fifo_empty ? '0 : head.rdata;
  assign bus.rsp_write = ~fifo_empty & head.write;
  assign bus.rsp_error = ~fifo_empty & head.error;

endmodule
